// File: rtl/cpu_multicycle.sv
// Multicycle RV32I-subset core: FETCH/DECODE/EXEC/WB/HALT sequencing over an
// external word-addressed instruction memory, with an internal register file.
module cpu_multicycle #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 8,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_valid,
    output logic                retire,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                halted
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam int SHAMT_W  = $clog2(DATA_WIDTH);

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t                    state_r;
    logic [PC_WIDTH-1:0]       pc_r;
    logic [31:0]               ir_r;
    logic [DATA_WIDTH-1:0]     rs1_val_r;
    logic [DATA_WIDTH-1:0]     rs2_val_r;
    logic [DATA_WIDTH-1:0]     result_r;
    logic                      wr_en_r;
    logic [PC_WIDTH-1:0]       next_pc_r;
    logic                      imem_req_r;
    logic [PC_WIDTH-1:0]       imem_addr_r;
    logic                      retire_r;
    logic                      halted_r;
    logic [DATA_WIDTH-1:0]     rf_r [NUM_REGS];

    logic [6:0]                opcode_s;
    logic [2:0]                funct3_s;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_s;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr_s;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_s;
    logic [DATA_WIDTH-1:0]     imm_i_s;
    logic [10:0]               br_off_raw_s;
    logic [PC_WIDTH-1:0]       br_off_s;
    logic [PC_WIDTH-1:0]       pc_inc_s;
    logic [PC_WIDTH-1:0]       br_tgt_s;
    logic [DATA_WIDTH-1:0]     op_b_s;
    logic [DATA_WIDTH-1:0]     alu_res_s;
    logic                      alu_ok_s;
    logic                      wr_en_s;
    logic [PC_WIDTH-1:0]       next_pc_s;
    logic                      halt_s;

    assign opcode_s   = ir_r[6:0];
    assign funct3_s   = ir_r[14:12];
    assign rs1_addr_s = ir_r[15 +: REG_ADDR_WIDTH];
    assign rs2_addr_s = ir_r[20 +: REG_ADDR_WIDTH];
    assign rd_addr_s  = ir_r[7 +: REG_ADDR_WIDTH];
    assign imm_i_s    = DATA_WIDTH'($signed(ir_r[31:20]));

    // B-immediate already divided by 4: its low two bits are dropped, not rounded.
    assign br_off_raw_s = {ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:9]};
    assign br_off_s     = PC_WIDTH'($signed(br_off_raw_s));
    assign pc_inc_s     = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign br_tgt_s     = pc_r + br_off_s;

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign retire    = retire_r;
    assign pc_out    = pc_r;
    assign halted    = halted_r;

    // ALU: operand selection and funct3 decode shared by OP and OP-IMM.
    always_comb begin
        alu_res_s = {DATA_WIDTH{1'b0}};
        alu_ok_s  = 1'b0;
        if (opcode_s == OPC_IMM) begin
            op_b_s = imm_i_s;
        end else begin
            op_b_s = rs2_val_r;
        end
        case (funct3_s)
            3'b000: begin
                alu_ok_s = 1'b1;
                if ((opcode_s == OPC_OP) && ir_r[30]) begin
                    alu_res_s = rs1_val_r - op_b_s;
                end else begin
                    alu_res_s = rs1_val_r + op_b_s;
                end
            end
            3'b111: begin
                alu_ok_s  = 1'b1;
                alu_res_s = rs1_val_r & op_b_s;
            end
            3'b110: begin
                alu_ok_s  = 1'b1;
                alu_res_s = rs1_val_r | op_b_s;
            end
            3'b100: begin
                alu_ok_s  = 1'b1;
                alu_res_s = rs1_val_r ^ op_b_s;
            end
            3'b001: begin
                alu_ok_s  = 1'b1;
                alu_res_s = rs1_val_r << op_b_s[SHAMT_W-1:0];
            end
            3'b101: begin
                // SRAI encoding (OP-IMM with IR[30] set) is treated as a NOP.
                if ((opcode_s == OPC_IMM) && ir_r[30]) begin
                    alu_ok_s  = 1'b0;
                    alu_res_s = {DATA_WIDTH{1'b0}};
                end else begin
                    alu_ok_s  = 1'b1;
                    alu_res_s = rs1_val_r >> op_b_s[SHAMT_W-1:0];
                end
            end
            3'b010: begin
                alu_ok_s  = 1'b1;
                alu_res_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(rs1_val_r) < $signed(op_b_s))};
            end
            default: begin
                alu_ok_s  = 1'b0;
                alu_res_s = {DATA_WIDTH{1'b0}};
            end
        endcase
    end

    // Instruction class decode: register write enable, next PC and halt request.
    always_comb begin
        wr_en_s   = 1'b0;
        next_pc_s = pc_inc_s;
        halt_s    = 1'b0;
        case (opcode_s)
            OPC_OP, OPC_IMM: begin
                wr_en_s = alu_ok_s;
            end
            OPC_BRANCH: begin
                case (funct3_s)
                    3'b000: begin
                        if (rs1_val_r == rs2_val_r) begin
                            next_pc_s = br_tgt_s;
                        end else begin
                            next_pc_s = pc_inc_s;
                        end
                    end
                    3'b001: begin
                        if (rs1_val_r != rs2_val_r) begin
                            next_pc_s = br_tgt_s;
                        end else begin
                            next_pc_s = pc_inc_s;
                        end
                    end
                    default: begin
                        next_pc_s = pc_inc_s;
                    end
                endcase
            end
            OPC_SYSTEM: begin
                halt_s = 1'b1;
            end
            default: begin
                wr_en_s   = 1'b0;
                next_pc_s = pc_inc_s;
            end
        endcase
    end

    // Main sequencer; all core outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_FETCH;
            pc_r        <= {PC_WIDTH{1'b0}};
            ir_r        <= 32'h0000_0000;
            rs1_val_r   <= {DATA_WIDTH{1'b0}};
            rs2_val_r   <= {DATA_WIDTH{1'b0}};
            result_r    <= {DATA_WIDTH{1'b0}};
            wr_en_r     <= 1'b0;
            next_pc_r   <= {PC_WIDTH{1'b0}};
            imem_req_r  <= 1'b1;
            imem_addr_r <= {PC_WIDTH{1'b0}};
            retire_r    <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    retire_r <= 1'b0;
                    if (imem_req_r && imem_valid) begin
                        ir_r       <= imem_rdata;
                        imem_req_r <= 1'b0;
                        state_r    <= ST_DECODE;
                    end else begin
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_r;
                    end
                end
                ST_DECODE: begin
                    rs1_val_r <= (rs1_addr_s == {REG_ADDR_WIDTH{1'b0}}) ? {DATA_WIDTH{1'b0}} : rf_r[rs1_addr_s];
                    rs2_val_r <= (rs2_addr_s == {REG_ADDR_WIDTH{1'b0}}) ? {DATA_WIDTH{1'b0}} : rf_r[rs2_addr_s];
                    state_r   <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_r  <= alu_res_s;
                    wr_en_r   <= wr_en_s;
                    next_pc_r <= next_pc_s;
                    if (halt_s) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else begin
                        retire_r <= 1'b1;
                        state_r  <= ST_WB;
                    end
                end
                ST_WB: begin
                    pc_r        <= next_pc_r;
                    imem_addr_r <= next_pc_r;
                    imem_req_r  <= 1'b1;
                    retire_r    <= 1'b0;
                    wr_en_r     <= 1'b0;
                    state_r     <= ST_FETCH;
                end
                ST_HALT: begin
                    imem_req_r <= 1'b0;
                    retire_r   <= 1'b0;
                    halted_r   <= 1'b1;
                end
                default: begin
                    state_r    <= ST_FETCH;
                    imem_req_r <= 1'b1;
                    retire_r   <= 1'b0;
                    halted_r   <= 1'b0;
                end
            endcase
        end
    end

    // Register file write port; x0 is never written so it always reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if ((state_r == ST_WB) && wr_en_r && (rd_addr_s != {REG_ADDR_WIDTH{1'b0}})) begin
            rf_r[rd_addr_s] <= result_r;
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: small program in a behavioural instruction
// memory, with hand-computed register, PC and timing expectations.
module tb_cpu_multicycle;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        retire;
    logic [7:0]  pc_out;
    logic        halted;

    logic [31:0] imem [256];
    logic [3:0]  stall_cnt = 4'd0;
    int          stall_target;
    int          cyc;
    int          vectors;
    int          miscompares;
    int          rel;
    int          st;

    cpu_multicycle #(.DATA_WIDTH(32), .PC_WIDTH(8), .REG_ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .retire     (retire),
        .pc_out     (pc_out),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers after stall_target refused cycles of an outstanding request.
    assign imem_rdata = imem[imem_addr];
    assign imem_valid = imem_req && (int'(stall_cnt) >= stall_target);

    always @(posedge clk) begin
        if (imem_req && !imem_valid) stall_cnt <= stall_cnt + 4'd1;
        else stall_cnt <= 4'd0;
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_retire(input int start, output int r);
        while (retire !== 1'b1 && (cyc - start) < 40) tick();
        r = cyc - start + 1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        stall_target = 0;
        rst = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
        imem[0]  = 32'h0050_0093; // ADDI x1,x0,5
        imem[1]  = 32'hFFD0_0113; // ADDI x2,x0,-3
        imem[2]  = 32'h0020_81B3; // ADD  x3,x1,x2
        imem[3]  = 32'h0000_0463; // BEQ  x0,x0,+8
        imem[4]  = 32'h0010_0393; // ADDI x7,x0,1 (skipped)
        imem[5]  = 32'h4011_0233; // SUB  x4,x2,x1
        imem[6]  = 32'h0012_22B3; // SLT  x5,x4,x1
        imem[7]  = 32'h0000_1463; // BNE  x0,x0,+8
        imem[8]  = 32'h0070_0013; // ADDI x0,x0,7
        imem[9]  = 32'h0000_0333; // ADD  x6,x0,x0
        imem[10] = 32'h0640_0413; // ADDI x8,x0,100 (stalled fetch)
        imem[11] = 32'h00F0_C493; // XORI x9,x1,15
        imem[12] = 32'h0030_9513; // SLLI x10,x1,3
        imem[13] = 32'h01C2_5593; // SRLI x11,x4,28
        imem[14] = 32'h0012_7633; // AND  x12,x4,x1
        imem[15] = 32'h0012_66B3; // OR   x13,x4,x1
        imem[16] = 32'h0000_077F; // unknown opcode, rd=x14
        imem[17] = 32'h0010_B7B3; // OP funct3=011, rd=x15
        imem[18] = 32'h0000_0073; // SYSTEM -> halt

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 1;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd1);
        chk("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_pc", {24'd0, pc_out}, 32'd0);
        chk("rst_ir", dut.ir_r, 32'd0);
        chk("rst_x1", dut.rf_r[1], 32'd0);

        wait_retire(1, rel);
        chk("retire1_cycle", cyc, 32'd4);
        tick();
        chk("retire_pulse_width", {31'd0, retire}, 32'd0);
        wait_retire(cyc, rel);
        chk("retire2_cycle", cyc, 32'd8);
        tick();
        wait_retire(cyc, rel);
        chk("retire3_cycle", cyc, 32'd12);
        tick();
        chk("x1_addi", dut.rf_r[1], 32'd5);
        chk("x2_addi_neg", dut.rf_r[2], 32'hFFFF_FFFD);
        chk("x3_add", dut.rf_r[3], 32'd2);
        chk("addr_before_beq", {24'd0, imem_addr}, 32'd3);

        st = cyc; wait_retire(st, rel);
        chk("beq_latency", rel, 32'd4);
        tick();
        chk("beq_taken_addr", {24'd0, imem_addr}, 32'd5);
        chk("beq_taken_pc", {24'd0, pc_out}, 32'd5);

        wait_retire(cyc, rel); tick();
        chk("x4_sub", dut.rf_r[4], 32'hFFFF_FFF8);
        wait_retire(cyc, rel); tick();
        chk("x5_slt", dut.rf_r[5], 32'd1);
        wait_retire(cyc, rel); tick();
        chk("bne_not_taken_addr", {24'd0, imem_addr}, 32'd8);
        wait_retire(cyc, rel); tick();
        chk("x0_write_discarded", dut.rf_r[0], 32'd0);
        wait_retire(cyc, rel);
        stall_target = 3;
        tick();
        chk("x6_add_zero", dut.rf_r[6], 32'd0);

        st = cyc;
        chk("stall_req_c1", {31'd0, imem_req}, 32'd1);
        tick();
        chk("stall_req_c2", {31'd0, imem_req}, 32'd1);
        tick();
        chk("stall_req_c3", {31'd0, imem_req}, 32'd1);
        chk("stall_addr", {24'd0, imem_addr}, 32'd10);
        wait_retire(st, rel);
        stall_target = 0;
        chk("stall_retire_latency", rel, 32'd7);
        tick();
        chk("x8_after_stall", dut.rf_r[8], 32'd100);

        wait_retire(cyc, rel); tick();
        chk("x9_xori", dut.rf_r[9], 32'd10);
        wait_retire(cyc, rel); tick();
        chk("x10_slli", dut.rf_r[10], 32'd40);
        wait_retire(cyc, rel); tick();
        chk("x11_srli", dut.rf_r[11], 32'h0000_000F);
        wait_retire(cyc, rel); tick();
        chk("x12_and", dut.rf_r[12], 32'd0);
        wait_retire(cyc, rel); tick();
        chk("x13_or", dut.rf_r[13], 32'hFFFF_FFFD);
        st = cyc; wait_retire(st, rel);
        chk("nop_latency", rel, 32'd4);
        tick();
        chk("x14_nop_no_write", dut.rf_r[14], 32'd0);
        chk("nop_pc_inc", {24'd0, imem_addr}, 32'd17);
        wait_retire(cyc, rel); tick();
        chk("x15_bad_funct3", dut.rf_r[15], 32'd0);
        chk("x7_skipped", dut.rf_r[7], 32'd0);
        chk("halt_fetch_addr", {24'd0, imem_addr}, 32'd18);

        tick();
        chk("halt_decode_retire", {31'd0, retire}, 32'd0);
        tick();
        chk("halt_exec_retire", {31'd0, retire}, 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_retire", {31'd0, retire}, 32'd0);
            chk("halt_pc", {24'd0, pc_out}, 32'd18);
            tick();
        end

        rst = 1'b1;
        tick();
        chk("rerst_addr", {24'd0, imem_addr}, 32'd0);
        chk("rerst_halted", {31'd0, halted}, 32'd0);
        chk("rerst_req", {31'd0, imem_req}, 32'd1);
        chk("rerst_pc", {24'd0, pc_out}, 32'd0);
        chk("rerst_x3", dut.rf_r[3], 32'd0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
